// File: rtl/dvi_ram_swap_if.sv
// Writer/scan-out side signals of the frame-buffer swap responder.
// master drives frame_done/vsync; slave (dvi_ram_swap) drives bank select and status.
interface dvi_ram_swap_if;
  logic        frame_done;
  logic        vsync;
  logic        rd_bank;
  logic        wr_bank;
  logic        swap_ack;
  logic        armed;
  logic        overrun;
  logic [15:0] swap_count;
  logic        timeout;

  modport master (
    output frame_done, vsync,
    input  rd_bank, wr_bank, swap_ack, armed, overrun, swap_count, timeout
  );

  modport slave (
    input  frame_done, vsync,
    output rd_bank, wr_bank, swap_ack, armed, overrun, swap_count, timeout
  );
endinterface

// File: rtl/dvi_ram_swap.sv
// Double-buffer swap: frame_done arms, next vsync edge toggles rd_bank and pulses swap_ack.
// Optional watchdog forcing a swap when vsync never arrives: `DVI_RAM_SWAP_TIMEOUT_EN.
module dvi_ram_swap #(
  parameter int ACK_CYCLES     = 4,
  parameter bit VSYNC_POL      = 1'b1,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input logic           clk125,
  input logic           reset,
  dvi_ram_swap_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, ACK} state_t;

  state_t      state, state_d;
  logic        fd_q, vs_q;
  logic        fd_edge, vs_edge, vs_lvl;
  logic        rd_bank_q, rd_d;
  logic        wr_bank_q;
  logic        swap_ack_q, ack_d;
  logic [3:0]  ack_cnt, cnt_d;
  logic        pending, pend_d;
  logic        overrun_q, ovr_d;
  logic [15:0] swap_count_q, count_d;
  logic        timeout_q, tmo_d;
  logic        wd_fire;
  logic        do_swap;

  assign vs_lvl  = VSYNC_POL ? bus.vsync : ~bus.vsync;
  assign fd_edge = bus.frame_done & ~fd_q;
  assign vs_edge = vs_lvl & ~vs_q;

`ifdef DVI_RAM_SWAP_TIMEOUT_EN
  localparam logic [21:0] WD_LIMIT = 22'(TIMEOUT_CYCLES - 1);
  logic [21:0] wd_cnt;

  // Held at zero outside ARMED, so every entry into ARMED starts a fresh window.
  always_ff @(posedge clk125 or negedge reset) begin
    if (!reset)               wd_cnt <= '0;
    else if (state != ARMED)  wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 22'd1;
  end

  assign wd_fire = (state == ARMED) && (wd_cnt == WD_LIMIT);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state;
    rd_d    = rd_bank_q;
    ack_d   = swap_ack_q;
    cnt_d   = ack_cnt;
    pend_d  = pending;
    ovr_d   = overrun_q;
    count_d = swap_count_q;
    tmo_d   = timeout_q;
    do_swap = 1'b0;
    case (state)
      IDLE: begin
        if (fd_edge) state_d = ARMED;
      end
      ARMED: begin
        if (vs_edge || wd_fire) begin
          do_swap = 1'b1;
          state_d = ACK;
          if (fd_edge) pend_d = 1'b1;
          if (!vs_edge) tmo_d = 1'b1;
        end else if (fd_edge) begin
          ovr_d = 1'b1;
        end
      end
      ACK: begin
        if (fd_edge) begin
          if (pending) ovr_d  = 1'b1;
          else         pend_d = 1'b1;
        end
        if (ack_cnt == 4'd0) begin
          ack_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = (pending || fd_edge) ? ARMED : IDLE;
        end else begin
          cnt_d = ack_cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_swap) begin
      rd_d    = ~rd_bank_q;
      count_d = swap_count_q + 16'd1;
      ack_d   = 1'b1;
      cnt_d   = 4'(ACK_CYCLES - 1);
    end
  end

  always_ff @(posedge clk125 or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fd_q         <= 1'b0;
      vs_q         <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_bank_q    <= 1'b1;
      swap_ack_q   <= 1'b0;
      ack_cnt      <= 4'd0;
      pending      <= 1'b0;
      overrun_q    <= 1'b0;
      swap_count_q <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state        <= state_d;
      fd_q         <= bus.frame_done;
      vs_q         <= vs_lvl;
      rd_bank_q    <= rd_d;
      wr_bank_q    <= ~rd_d;
      swap_ack_q   <= ack_d;
      ack_cnt      <= cnt_d;
      pending      <= pend_d;
      overrun_q    <= ovr_d;
      swap_count_q <= count_d;
      timeout_q    <= tmo_d;
    end
  end

  assign bus.rd_bank    = rd_bank_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.armed      = (state == ARMED);
  assign bus.overrun    = overrun_q;
  assign bus.swap_count = swap_count_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_dvi_ram_swap.sv
// Directed bench for dvi_ram_swap: 20 ns clock, ACK_CYCLES=4, VSYNC_POL=1, TIMEOUT_CYCLES=100.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_dvi_ram_swap;
  logic clk125 = 1'b0;
  logic reset  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  dvi_ram_swap_if bus ();

  dvi_ram_swap #(.ACK_CYCLES(4), .VSYNC_POL(1'b1), .TIMEOUT_CYCLES(100)) dut (
    .clk125 (clk125),
    .reset  (reset),
    .bus    (bus)
  );

  always #10 clk125 = ~clk125;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk125);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.frame_done = 1'b0;
    bus.vsync      = 1'b0;
    reset          = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_fd();
    bus.frame_done = 1'b1;
    cyc(1);
    bus.frame_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.rd_bank !== 1'b0)      begin n_bad++; $display("FAIL reset_rd_bank got %b want 0", bus.rd_bank); end
    n_cmp++; if (bus.wr_bank !== 1'b1)      begin n_bad++; $display("FAIL reset_wr_bank got %b want 1", bus.wr_bank); end
    n_cmp++; if ({bus.swap_ack, bus.armed, bus.overrun, bus.timeout} !== 4'b0000)
      begin n_bad++; $display("FAIL reset_flags got %b want 0000", {bus.swap_ack, bus.armed, bus.overrun, bus.timeout}); end
    n_cmp++; if (bus.swap_count !== 16'd0)  begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.swap_count); end
  endtask

  task automatic test_basic_swap();
    int hi;
    do_reset();
    bus.frame_done = 1'b1;
    #45;
    bus.frame_done = 1'b0;
    @(posedge clk125); #1;
    n_cmp++; if (bus.armed !== 1'b1) begin n_bad++; $display("FAIL basic_armed got %b want 1", bus.armed); end
    cyc(8);
    n_cmp++; if (bus.armed !== 1'b1 || bus.swap_count !== 16'd0)
      begin n_bad++; $display("FAIL basic_wait got armed=%b cnt=%0d want 1/0", bus.armed, bus.swap_count); end
    bus.vsync = 1'b1;
    cyc(1);
    n_cmp++; if (bus.rd_bank !== 1'b1 || bus.wr_bank !== 1'b0)
      begin n_bad++; $display("FAIL basic_banks got rd=%b wr=%b want 1/0", bus.rd_bank, bus.wr_bank); end
    n_cmp++; if (bus.swap_ack !== 1'b1 || bus.swap_count !== 16'd1 || bus.armed !== 1'b0)
      begin n_bad++; $display("FAIL basic_ack got ack=%b cnt=%0d armed=%b want 1/1/0", bus.swap_ack, bus.swap_count, bus.armed); end
    hi = 1;
    cyc(1);
    bus.vsync = 1'b0;
    if (bus.swap_ack) hi++;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus.swap_ack) hi++;
    end
    n_cmp++; if (hi !== 4) begin n_bad++; $display("FAIL basic_ack_width got %0d want 4", hi); end
    n_cmp++; if (bus.armed !== 1'b0 || bus.swap_count !== 16'd1 || bus.rd_bank !== 1'b1)
      begin n_bad++; $display("FAIL basic_after got armed=%b cnt=%0d rd=%b want 0/1/1", bus.armed, bus.swap_count, bus.rd_bank); end
  endtask

  task automatic test_overrun();
    do_reset();
    pulse_fd();
    cyc(2);
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early got %b want 0", bus.overrun); end
    pulse_fd();
    cyc(2);
    n_cmp++; if (bus.overrun !== 1'b1 || bus.armed !== 1'b1)
      begin n_bad++; $display("FAIL ovr_set got ovr=%b armed=%b want 1/1", bus.overrun, bus.armed); end
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    cyc(10);
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    cyc(6);
    n_cmp++; if (bus.swap_count !== 16'd1 || bus.rd_bank !== 1'b1)
      begin n_bad++; $display("FAIL ovr_one_swap got cnt=%0d rd=%b want 1/1", bus.swap_count, bus.rd_bank); end
    n_cmp++; if (bus.overrun !== 1'b1 || bus.armed !== 1'b0)
      begin n_bad++; $display("FAIL ovr_sticky got ovr=%b armed=%b want 1/0", bus.overrun, bus.armed); end
  endtask

  task automatic test_simultaneous_idle();
    do_reset();
    bus.frame_done = 1'b1;
    bus.vsync      = 1'b1;
    cyc(1);
    bus.frame_done = 1'b0;
    bus.vsync      = 1'b0;
    n_cmp++; if (bus.armed !== 1'b1 || bus.swap_ack !== 1'b0 || bus.rd_bank !== 1'b0)
      begin n_bad++; $display("FAIL simul_arm got armed=%b ack=%b rd=%b want 1/0/0", bus.armed, bus.swap_ack, bus.rd_bank); end
    cyc(3);
    n_cmp++; if (bus.armed !== 1'b1 || bus.swap_count !== 16'd0)
      begin n_bad++; $display("FAIL simul_hold got armed=%b cnt=%0d want 1/0", bus.armed, bus.swap_count); end
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    n_cmp++; if (bus.swap_count !== 16'd1 || bus.rd_bank !== 1'b1 || bus.swap_ack !== 1'b1)
      begin n_bad++; $display("FAIL simul_swap got cnt=%0d rd=%b ack=%b want 1/1/1", bus.swap_count, bus.rd_bank, bus.swap_ack); end
    cyc(6);
  endtask

  task automatic test_rearm_in_ack();
    do_reset();
    pulse_fd();
    cyc(2);
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    n_cmp++; if (bus.swap_ack !== 1'b1) begin n_bad++; $display("FAIL rearm_ack1 got %b want 1", bus.swap_ack); end
    pulse_fd();
    cyc(4);
    n_cmp++; if (bus.armed !== 1'b1 || bus.swap_ack !== 1'b0 || bus.overrun !== 1'b0)
      begin n_bad++; $display("FAIL rearm_state got armed=%b ack=%b ovr=%b want 1/0/0", bus.armed, bus.swap_ack, bus.overrun); end
    cyc(3);
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    n_cmp++; if (bus.swap_count !== 16'd2 || bus.rd_bank !== 1'b0 || bus.wr_bank !== 1'b1)
      begin n_bad++; $display("FAIL rearm_swap2 got cnt=%0d rd=%b wr=%b want 2/0/1", bus.swap_count, bus.rd_bank, bus.wr_bank); end
    cyc(6);
    n_cmp++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL rearm_idle got armed=%b want 0", bus.armed); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.frame_done = 1'b1;
`ifdef DVI_RAM_SWAP_TIMEOUT_EN
    n = 0;
    while (!bus.swap_ack && n < 300) begin
      cyc(1);
      bus.frame_done = 1'b0;
      n++;
    end
    n_cmp++; if (n !== 101) begin n_bad++; $display("FAIL tmo_delay got %0d cycles want 101", n); end
    n_cmp++; if (bus.timeout !== 1'b1 || bus.rd_bank !== 1'b1 || bus.swap_count !== 16'd1)
      begin n_bad++; $display("FAIL tmo_swap got tmo=%b rd=%b cnt=%0d want 1/1/1", bus.timeout, bus.rd_bank, bus.swap_count); end
    cyc(1);
    reset = 1'b0;
    #2;
    n_cmp++; if (bus.swap_ack !== 1'b0 || bus.timeout !== 1'b0 || bus.rd_bank !== 1'b0 || bus.swap_count !== 16'd0)
      begin n_bad++; $display("FAIL tmo_reset got ack=%b tmo=%b rd=%b cnt=%0d want 0/0/0/0", bus.swap_ack, bus.timeout, bus.rd_bank, bus.swap_count); end
    cyc(2);
    reset = 1'b1;
`else
    cyc(1);
    bus.frame_done = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (bus.swap_ack) n++;
    end
    n_cmp++; if (n !== 0 || bus.armed !== 1'b1 || bus.timeout !== 1'b0)
      begin n_bad++; $display("FAIL notmo_wait got acks=%0d armed=%b tmo=%b want 0/1/0", n, bus.armed, bus.timeout); end
`endif
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    pulse_fd();
    cyc(2);
    bus.vsync = 1'b1;
    cyc(1);
    bus.vsync = 1'b0;
    cyc(1);
    n_cmp++; if (bus.swap_ack !== 1'b1) begin n_bad++; $display("FAIL rstack_pre got %b want 1", bus.swap_ack); end
    #4;
    reset = 1'b0;
    #2;
    n_cmp++; if (bus.swap_ack !== 1'b0 || bus.rd_bank !== 1'b0 || bus.wr_bank !== 1'b1 || bus.swap_count !== 16'd0)
      begin n_bad++; $display("FAIL rstack_async got ack=%b rd=%b wr=%b cnt=%0d want 0/0/1/0", bus.swap_ack, bus.rd_bank, bus.wr_bank, bus.swap_count); end
    cyc(2);
    reset = 1'b1;
    cyc(6);
    n_cmp++; if (bus.swap_ack !== 1'b0 || bus.armed !== 1'b0)
      begin n_bad++; $display("FAIL rstack_after got ack=%b armed=%b want 0/0", bus.swap_ack, bus.armed); end
  endtask

  initial begin
    bus.frame_done = 1'b0;
    bus.vsync      = 1'b0;
    test_reset();
    test_basic_swap();
    test_overrun();
    test_simultaneous_idle();
    test_rearm_in_ack();
    test_timeout();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout simulation did not finish within 2 ms");
    $fatal(1);
  end
endmodule
